// File: rtl/exe_wb_stage.sv
// Execute stage with EXE/WB pipeline register.
// Single-cycle ALU ops plus an iterative shift-add multiply that stalls upstream.
module exe_wb_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] rdata1_in,
    input  logic [DSIZE-1:0] rdata2_in,
    input  logic [DSIZE-1:0] imm_in,
    input  logic [2:0]       opcode_in,
    input  logic             alusrc_in,
    input  logic [ASIZE-1:0] waddr_in,
    output logic [DSIZE-1:0] alu_result_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             wen_out,
    output logic             stall
);

    localparam int CW = $clog2(DSIZE + 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DSIZE-1:0] mcand_q, mcand_d;
    logic [DSIZE-1:0] mplier_q, mplier_d;
    logic [DSIZE-1:0] acc_q, acc_d;
    logic [ASIZE-1:0] mwa_q, mwa_d;
    logic [DSIZE-1:0] res_q, res_d;
    logic [ASIZE-1:0] wa_q, wa_d;
    logic             wen_q, wen_d;

    logic [DSIZE-1:0] opb;
    logic [DSIZE-1:0] alu;

    assign opb = alusrc_in ? imm_in : rdata2_in;

    // Single-cycle ALU; NOP and MUL produce zero here.
    always_comb begin
        alu = '0;
        unique case (opcode_in)
            OP_ADD:  alu = rdata1_in + opb;
            OP_SUB:  alu = rdata1_in - opb;
            OP_AND:  alu = rdata1_in & opb;
            OP_OR:   alu = rdata1_in | opb;
            OP_XOR:  alu = rdata1_in ^ opb;
            OP_SLT:  alu = {{(DSIZE-1){1'b0}},
                            $signed(rdata1_in) < $signed(opb)};
            default: alu = '0;
        endcase
    end

    // Multiply FSM next state, stall and output-register next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mwa_d    = mwa_q;
        res_d    = '0;
        wa_d     = '0;
        wen_d    = 1'b0;
        stall    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (opcode_in == OP_MUL) begin
                    stall    = 1'b1;
                    mcand_d  = rdata1_in;
                    mplier_d = opb;
                    mwa_d    = waddr_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end else begin
                    res_d = alu;
                    wa_d  = waddr_in;
                    wen_d = (opcode_in != OP_NOP);
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(DSIZE - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_d   = acc_q;
                wa_d    = mwa_q;
                wen_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, multiply datapath and EXE/WB register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mwa_q    <= '0;
            res_q    <= '0;
            wa_q     <= '0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mwa_q    <= mwa_d;
            res_q    <= res_d;
            wa_q     <= wa_d;
            wen_q    <= wen_d;
        end
    end

    assign alu_result_out = res_q;
    assign waddr_out      = wa_q;
    assign wen_out        = wen_q;

endmodule

// File: tb/tb_exe_wb_stage.sv
// Scoreboard bench for exe_wb_stage: driver acts as upstream,
// monitor pops expected writebacks whenever wen_out is seen.
module tb_exe_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rdata1_in, rdata2_in, imm_in;
    logic [2:0]  opcode_in;
    logic        alusrc_in;
    logic [3:0]  waddr_in;
    logic [15:0] alu_result_out;
    logic [3:0]  waddr_out;
    logic        wen_out;
    logic        stall;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  wa;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    exe_wb_stage #(.DSIZE(16), .ASIZE(4)) dut (
        .clk(clk),
        .rst(rst),
        .rdata1_in(rdata1_in),
        .rdata2_in(rdata2_in),
        .imm_in(imm_in),
        .opcode_in(opcode_in),
        .alusrc_in(alusrc_in),
        .waddr_in(waddr_in),
        .alu_result_out(alu_result_out),
        .waddr_out(waddr_out),
        .wen_out(wen_out),
        .stall(stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model from the operation definitions.
    function automatic logic [15:0] model(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] p;
        case (op)
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd7: begin
                p = {16'd0, a} * {16'd0, b};
                return p[15:0];
            end
            default: return 16'd0;
        endcase
    endfunction

    // Monitor: every writeback must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (wen_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_result", alu_result_out, e.res);
                    chk("wb_waddr", waddr_out, e.wa);
                    chk("wb_cycle", cyc, e.cyc);
                end
            end else begin
                chk("bubble_result", alu_result_out, 0);
            end
        end
    end

    // Present one instruction and hold it while stall is high.
    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm,
                         input logic src, input logic [3:0] wa,
                         input bit jig);
        logic [15:0] bsel;
        int          stalls;
        int          k;
        exp_t        e;
        stalls    = 0;
        bsel      = src ? imm : b;
        rdata1_in = a;
        rdata2_in = b;
        imm_in    = imm;
        opcode_in = op;
        alusrc_in = src;
        waddr_in  = wa;
        k = cyc;
        if (op == 3'd7) begin
            e.res = model(op, a, bsel);
            e.wa  = wa;
            e.cyc = k + 18;
            exp_q.push_back(e);
        end else if (op != 3'd0) begin
            e.res = model(op, a, bsel);
            e.wa  = wa;
            e.cyc = k + 1;
            exp_q.push_back(e);
        end
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 40) begin
                chk("stall_timeout", 1, 0);
                break;
            end
            if (jig && stalls >= 2) begin
                rdata1_in = 16'($urandom);
                rdata2_in = 16'($urandom);
                imm_in    = 16'($urandom);
            end
        end
        chk("stall_len", stalls, (op == 3'd7) ? 17 : 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        rdata1_in = 16'd5;
        rdata2_in = 16'd6;
        imm_in    = 16'd9;
        opcode_in = 3'd1;
        alusrc_in = 1'b0;
        waddr_in  = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", alu_result_out, 0);
        chk("rst_waddr", waddr_out, 0);
        chk("rst_wen", wen_out, 0);
        chk("rst_stall", stall, 0);
        rst       = 1'b0;
        opcode_in = 3'd0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        issue(3'd1, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 4'd3, 0);
        issue(3'd2, 16'd5, 16'd7, 16'h1234, 1'b0, 4'd4, 0);
        issue(3'd6, 16'h8000, 16'h0001, 16'h0, 1'b0, 4'd5, 0);
        issue(3'd6, 16'h0001, 16'h8000, 16'h0, 1'b0, 4'd6, 0);
        issue(3'd3, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0, 4'd7, 0);
        issue(3'd0, 16'h1111, 16'h2222, 16'h0, 1'b0, 4'd8, 0);
        issue(3'd7, 16'd300, 16'd7, 16'h0, 1'b0, 4'd9, 0);
        issue(3'd7, 16'h0100, 16'h0100, 16'h0, 1'b0, 4'd10, 0);
        issue(3'd7, 16'd300, 16'd7, 16'h0, 1'b0, 4'd11, 1);
        issue(3'd1, 16'd1, 16'd1, 16'h0, 1'b0, 4'd12, 0);
        issue(3'd7, 16'd3, 16'd5, 16'h0, 1'b0, 4'd1, 0);
        issue(3'd7, 16'd6, 16'd7, 16'h0, 1'b0, 4'd2, 0);
        opcode_in = 3'd0;
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        rdata1_in = 16'd123;
        rdata2_in = 16'd45;
        alusrc_in = 1'b0;
        waddr_in  = 4'd13;
        opcode_in = 3'd7;
        repeat (6) @(posedge clk);
        #1;
        rst       = 1'b1;
        opcode_in = 3'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_result", alu_result_out, 0);
        chk("midrst_wen", wen_out, 0);
        chk("midrst_stall", stall, 0);
        @(posedge clk);
        #1;
        issue(3'd1, 16'd3, 16'd4, 16'h0, 1'b0, 4'd14, 0);

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom), 0);
        end
        opcode_in = 3'd0;
        repeat (25) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
